// File: rtl/fir_stim_src.sv
// Burst-capturing stimulus source: scales LFSR words into a small FIFO that feeds
// the FIR sample port over valid/ready, and keeps a checksum of delivered samples.
module fir_stim_src #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] lfsr_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        csum_q, csum_d;
  logic [AW-1:0]            wr_q, rd_q;
  logic [AW:0]              occ_q;
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic                     push, pop, full, empty;

  function automatic logic signed [DATA_W-1:0] scale(input logic [DATA_W-1:0] w);
    logic signed [DATA_W-1:0] s;
    s = w;
    return s >>> SHIFT;
  endfunction

  assign full         = (occ_q == OCC_FULL);
  assign empty        = (occ_q == '0);
  assign pop          = !empty && sample_ready;
  assign sample_valid = !empty;
  // Empty FIFO presents zero so the port is deterministic out of reset.
  assign sample_out   = empty ? '0 : mem_q[rd_q];
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign checksum     = csum_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = burst_len;
          cnt_d   = '0;
          csum_d  = '0;
          state_d = (burst_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!full) begin
          push  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (pop) csum_d = csum_q + sample_out;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage is data only; pointers and occupancy decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= scale(lfsr_in);
  end

endmodule
